operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Read side of the 16 x 18-bit register file.
- Accepts operand-read requests (two register addresses) over a valid/ready handshake and returns both register values one cycle later.
- Forwards a same-cycle write, and buffers up to two results when the consumer (ALU/decode stage) stalls.
- Buffered operands snoop later writes so they never go stale.

Parameters:
- DATA_W, 18, register width
- ADDR_W, 4, register address width
- NUM_REGS, 16, register count (must equal 2**ADDR_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_bus  in  NUM_REGS*DATA_W  flattened current register contents; register k occupies bits [k*DATA_W +: DATA_W]
- reg_write  in  1  write strobe of the register file write port
- write_register  in  ADDR_W  write address
- write_data  in  DATA_W  write value
- req_valid  in  1  read request valid
- req_ready  out  1  request can be accepted this cycle
- read_register_1  in  ADDR_W  first operand address
- read_register_2  in  ADDR_W  second operand address
- out_valid  out  1  operand pair valid
- out_ready  in  1  consumer takes pair this cycle
- out_value_1  out  DATA_W  first operand value
- out_value_2  out  DATA_W  second operand value

Behaviour:
- Reset (async, rst_n=0): state EMPTY; out_valid=0, out_value_1/2=0, req_ready=1, skid entry cleared. Release is synchronous to clk.
- Storage: head entry (drives the outputs) and skid entry. Each entry holds addr_1, addr_2, val_1, val_2.
- accept = req_valid & req_ready. pop = out_valid & out_ready.
- FSM (count of valid entries):
  - EMPTY: accept -> ONE (load head).
  - ONE:
    - accept & !pop -> FULL (load skid).
    - accept & pop -> ONE (load head with new request).
    - pop & !accept -> EMPTY.
    - neither -> ONE.
  - FULL:
    - pop -> ONE (skid moves to head).
    - no accept is possible in FULL.
- req_ready = (state != FULL), decoded from the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY), registered.
- Capture value at accept, per operand: if reg_write and write_register == addr, use write_data (same-cycle bypass); otherwise use the reg_bus slice.
- Latency: request accepted on edge N appears at the outputs after edge N (out_valid=1 in cycle N+1) when EMPTY, or when ONE with a simultaneous pop.
- Snoop: every cycle, for each valid entry (head and skid) and each operand, if reg_write and write_register == stored addr, val <= write_data. This includes:
  - the skid->head move in the same cycle,
  - a head entry being held because out_ready=0.
- A popped entry is not updated.
- Both operand addresses equal: both fields are captured and updated identically.
- No register is hardwired; address 0 is ordinary.
- Order is strictly FIFO; no request is dropped or duplicated.
- Data outputs hold their value while out_valid=1 and out_ready=0, except for snoop updates. Consumers treat a snoop update as newer data, not a protocol violation.
- When pop leaves the block EMPTY, out_value_1/2 retain their last value (don't-care).
- Reset mid-operation: all entries are discarded immediately and the FSM returns to EMPTY.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W=18, ADDR_W=4, NUM_REGS=16.
  - An operand-entry struct {addr_1, addr_2, val_1, val_2}.
  - FSM state enum {EMPTY, ONE, FULL}.
- One sub-module, operand_entry_snoop: a combinational function that applies a write-port snoop or bypass to an entry. It is instantiated for the new-request capture, the head entry and the skid entry.

Test Plan:
- Reset, then preload r3=0x00A5, r7=0x3FFFF. Request (3,7) with out_ready=1 -> next cycle out_valid=1, out_value_1=0x00A5, out_value_2=0x3FFFF. req_ready stays 1 throughout.
- Bypass: request (5,5) while reg_write=1, write_register=5, write_data=0x12345, and reg_bus r5=0 -> both outputs=0x12345.
- Stall/skid:
  - Hold out_ready=0 and issue (1,2) then (4,6) -> req_ready drops to 0 after the second accept.
  - Third request is held (not accepted).
  - Raise out_ready -> pairs return in order (1,2), (4,6), (third).
- Snoop while stalled: head=(2,9) and skid=(9,2). Write r9=0x00777 -> head out_value_2=0x00777 next cycle. After pop, head shows out_value_1=0x00777.
- Back-to-back throughput: 10 requests with out_ready=1 -> 10 pairs on 10 consecutive cycles, with no bubbles after the first.
- Async reset mid-operation: assert rst_n=0 in FULL, between clock edges -> out_valid=0 and req_ready=1 immediately. No stale pair appears after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, operand-entry record and fetch FSM encoding for the
// register-file read path.
package cpu_pkg;

    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr_1;
        logic [ADDR_W-1:0] addr_2;
        logic [DATA_W-1:0] val_1;
        logic [DATA_W-1:0] val_2;
    } operand_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fetch_state_t;

    function automatic logic [DATA_W-1:0] reg_slice(
        input logic [NUM_REGS*DATA_W-1:0] bus,
        input logic [ADDR_W-1:0]          idx
    );
        return bus[idx*DATA_W +: DATA_W];
    endfunction

endpackage

// File: rtl/operand_fetch_snoop.sv
// Applies the register-file write port to an operand entry: any operand whose
// address matches the write address takes the write data.
module operand_entry_snoop
    import cpu_pkg::*;
(
    input  operand_entry_t    entry_in,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    output operand_entry_t    entry_out
);

    always_comb begin
        entry_out = entry_in;
        if (reg_write && (write_register == entry_in.addr_1)) begin
            entry_out.val_1 = write_data;
        end
        if (reg_write && (write_register == entry_in.addr_2)) begin
            entry_out.val_2 = write_data;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Register-file read side: captures operand pairs on a valid/ready handshake
// into a two-deep head/skid buffer whose entries track later writes.
//
// state | meaning
// EMPTY | no entry valid, outputs idle
// ONE   | head valid, skid free
// FULL  | head and skid valid, requests blocked
module operand_fetch
    import cpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REGS*DATA_W-1:0] reg_bus,
    input  logic                       reg_write,
    input  logic [ADDR_W-1:0]          write_register,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          read_register_1,
    input  logic [ADDR_W-1:0]          read_register_2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_value_1,
    output logic [DATA_W-1:0]          out_value_2
);

    fetch_state_t   state_q, state_d;
    operand_entry_t head_q, head_d;
    operand_entry_t skid_q, skid_d;
    operand_entry_t new_raw, new_entry, head_snoop, skid_snoop;
    logic           accept, pop;

    assign new_raw.addr_1 = read_register_1;
    assign new_raw.addr_2 = read_register_2;
    assign new_raw.val_1  = reg_slice(reg_bus, read_register_1);
    assign new_raw.val_2  = reg_slice(reg_bus, read_register_2);

    // The same snoop logic gives the same-cycle bypass on capture.
    operand_entry_snoop u_snoop_new (
        .entry_in       (new_raw),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .entry_out      (new_entry)
    );

    operand_entry_snoop u_snoop_head (
        .entry_in       (head_q),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .entry_out      (head_snoop)
    );

    operand_entry_snoop u_snoop_skid (
        .entry_in       (skid_q),
        .reg_write      (reg_write),
        .write_register (write_register),
        .write_data     (write_data),
        .entry_out      (skid_snoop)
    );

    assign req_ready   = (state_q != FULL);
    assign out_valid   = (state_q != EMPTY);
    assign out_value_1 = head_q.val_1;
    assign out_value_2 = head_q.val_2;

    assign accept = req_valid & req_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = new_entry;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_d = FULL;
                    head_d  = head_snoop;
                    skid_d  = new_entry;
                end else if (accept && pop) begin
                    head_d  = new_entry;
                end else if (pop) begin
                    // Popped head keeps its last value on the idle outputs.
                    state_d = EMPTY;
                end else begin
                    head_d  = head_snoop;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = skid_snoop;
                end else begin
                    head_d  = head_snoop;
                    skid_d  = skid_snoop;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a register-file model drives reg_bus and
// a FIFO of accepted address pairs supplies the expected operand values.
module tb_operand_fetch;

    localparam int DW = 18;
    localparam int AW = 4;
    localparam int NR = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR*DW-1:0] reg_bus;
    logic            reg_write = 1'b0;
    logic [AW-1:0]   write_register = '0;
    logic [DW-1:0]   write_data = '0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AW-1:0]   read_register_1 = '0;
    logic [AW-1:0]   read_register_2 = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_value_1;
    logic [DW-1:0]   out_value_2;

    logic [DW-1:0]   regs [NR];

    typedef struct {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
    } req_t;

    req_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   pops = 0;
    bit   last_acc = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NR; k++) begin : g_bus
        assign reg_bus[k*DW +: DW] = regs[k];
    end

    operand_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .reg_bus         (reg_bus),
        .reg_write       (reg_write),
        .write_register  (write_register),
        .write_data      (write_data),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .read_register_1 (read_register_1),
        .read_register_2 (read_register_2),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_value_1     (out_value_1),
        .out_value_2     (out_value_2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
            $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check at the falling edge, then commit model writes
    // just after the rising edge so they never race the DUT sampling.
    task automatic tick();
        bit   exp_valid, exp_ready;
        req_t e;
        @(negedge clk);
        exp_valid = (sb.size() != 0);
        exp_ready = (sb.size() < 2);
        check("out_valid", out_valid, exp_valid);
        check("req_ready", req_ready, exp_ready);
        last_acc = req_valid && exp_ready;
        if (exp_valid && out_ready) begin
            e = sb.pop_front();
            check("out_value_1", out_value_1, regs[e.a1]);
            check("out_value_2", out_value_2, regs[e.a2]);
            pops++;
        end
        if (last_acc) begin
            e.a1 = read_register_1;
            e.a2 = read_register_2;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (reg_write) regs[write_register] = write_data;
        reg_write = 1'b0;
    endtask

    task automatic request(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        req_valid = 1'b1;
        read_register_1 = a1;
        read_register_2 = a2;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        reg_write = 1'b1;
        write_register = a;
        write_data = d;
    endtask

    initial begin
        int  p0;
        bit  done;
        for (int i = 0; i < NR; i++) regs[i] = DW'(i * 18'h111);

        // Reset state
        tick();
        tick();
        check("rst_out_value_1", out_value_1, 0);
        check("rst_out_value_2", out_value_2, 0);
        rst_n = 1'b1;

        // Basic fetch with preloaded registers
        regs[3] = 18'h000A5;
        regs[7] = 18'h3FFFF;
        out_ready = 1'b1;
        request(3, 7);
        tick();
        req_valid = 1'b0;
        check("basic_valid", out_valid, 1);
        check("basic_v1", out_value_1, 18'h000A5);
        check("basic_v2", out_value_2, 18'h3FFFF);
        tick();

        // Same-cycle write bypass, both operands on one address
        regs[5] = '0;
        request(5, 5);
        write_reg(5, 18'h12345);
        tick();
        req_valid = 1'b0;
        check("bypass_v1", out_value_1, 18'h12345);
        check("bypass_v2", out_value_2, 18'h12345);
        tick();

        // Stall into skid, third request held, drain in order
        regs[1] = 18'h01001; regs[2] = 18'h02002; regs[4] = 18'h04004;
        regs[6] = 18'h06006; regs[8] = 18'h08008; regs[10] = 18'h0A00A;
        out_ready = 1'b0;
        request(1, 2);
        tick();
        request(4, 6);
        tick();
        check("stall_full_ready", req_ready, 0);
        request(8, 10);
        tick();
        tick();
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (last_acc) req_valid = 1'b0;
            done = (sb.size() == 0) && !req_valid;
        end
        check("stall_drain_done", done, 1);

        // Snoop on held head and on skid, including during skid->head move
        out_ready = 1'b0;
        request(2, 9);
        tick();
        request(9, 2);
        tick();
        req_valid = 1'b0;
        write_reg(9, 18'h00777);
        tick();
        check("snoop_head_v2", out_value_2, 18'h00777);
        out_ready = 1'b1;
        write_reg(2, 18'h02222);
        tick();
        check("snoop_skid_v1", out_value_1, 18'h00777);
        check("snoop_move_v2", out_value_2, 18'h02222);
        tick();

        // Back-to-back throughput with random writes in flight
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            request(AW'(i), AW'(15 - i));
            write_reg(AW'($urandom_range(0, NR - 1)), DW'($urandom_range(0, (1 << DW) - 1)));
            tick();
        end
        req_valid = 1'b0;
        tick();
        check("throughput_pops", pops - p0, 10);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        request(11, 12);
        tick();
        request(13, 14);
        tick();
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", out_valid, 0);
        check("arst_req_ready", req_ready, 1);
        check("arst_value_1", out_value_1, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        request(11, 12);
        tick();
        req_valid = 1'b0;
        tick();
        check("final_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
